// File: rtl/dataflow_pkg.sv
// rtl/dataflow_pkg.sv - shared types and constants for the external bus reader
// Contents:
//   reader_state_e : reader FSM states (IDLE, WAIT)
//   ADDRESS_WIDTH  : external memory address width
//   DATA_WIDTH     : external memory data width
//   DEFAULT_DATA   : value the data latch takes on reset and on an abandoned read
package dataflow_pkg;

    localparam int ADDRESS_WIDTH = 16;
    localparam int DATA_WIDTH    = 8;

    localparam logic [DATA_WIDTH-1:0] DEFAULT_DATA = 8'hEA;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } reader_state_e;

endpackage

// File: rtl/read_timeout_counter.sv
// rtl/read_timeout_counter.sv - WAIT-cycle counter with terminal-count flag
// Ports:
//   clk        : system clock
//   nrst       : synchronous active-low reset, clears the count
//   clear_i    : restart the count from zero (has priority over enable_i)
//   enable_i   : count one cycle
//   terminal_o : count has reached TERMINAL_COUNT
module read_timeout_counter #(
    parameter int TERMINAL_COUNT = 15
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign terminal_o = (count_q == 8'(TERMINAL_COUNT));

    // Saturates at the terminal value so a stalled consumer never sees a wrap.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !terminal_o) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/external_bus_reader.sv
// rtl/external_bus_reader.sv - single-outstanding external memory read engine
// Optional feature macro: BUS_READER_TIMEOUT_EN (abandon a read after TIMEOUT_CYCLES WAIT cycles)
// Ports:
//   clk, nrst                        : clock, synchronous active-low reset
//   address_low_in, address_high_in  : ABL/ABH from the internal dataflow
//   read_request                     : level request, sampled only in IDLE
//   mem_address                      : {ABH, ABL} captured at request acceptance
//   mem_read_valid                   : read strobe to memory, high while in WAIT
//   mem_ready, mem_data              : memory response
//   data_latch_out, data_valid       : last completed read data and its one-cycle update pulse
//   stall                            : read outstanding (WAIT)
//   timeout_error                    : sticky, last read was abandoned
module external_bus_reader #(
    parameter logic [dataflow_pkg::DATA_WIDTH-1:0] DEFAULT_DATA   = dataflow_pkg::DEFAULT_DATA,
    parameter int                                  TIMEOUT_CYCLES = 16
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic [7:0]                             address_low_in,
    input  logic [7:0]                             address_high_in,
    input  logic                                   read_request,
    output logic [dataflow_pkg::ADDRESS_WIDTH-1:0] mem_address,
    output logic                                   mem_read_valid,
    input  logic                                   mem_ready,
    input  logic [dataflow_pkg::DATA_WIDTH-1:0]    mem_data,
    output logic [dataflow_pkg::DATA_WIDTH-1:0]    data_latch_out,
    output logic                                   data_valid,
    output logic                                   stall,
    output logic                                   timeout_error
);

    localparam int AW = dataflow_pkg::ADDRESS_WIDTH;
    localparam int DW = dataflow_pkg::DATA_WIDTH;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    dataflow_pkg::reader_state_e state_q, state_d;

    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] data_latch_q,  data_latch_d;
    logic          data_valid_q,  data_valid_d;
    // Memory data is captured first and transferred to the latch one cycle
    // later, so a zero-wait read spends two cycles in WAIT.
    logic          rd_done_q,     rd_done_d;
    logic [DW-1:0] rd_data_q,     rd_data_d;

    logic in_wait;
    logic accept;

    assign in_wait = (state_q == dataflow_pkg::ST_WAIT);
    assign accept  = (state_q == dataflow_pkg::ST_IDLE) && read_request;

    assign stall          = in_wait;
    assign mem_read_valid = in_wait;
    assign mem_address    = mem_address_q;
    assign data_latch_out = data_latch_q;
    assign data_valid     = data_valid_q;

`ifdef BUS_READER_TIMEOUT_EN
    logic timeout_error_q, timeout_error_d;
    logic terminal;
    logic timeout_hit;

    // Cycles after the data is captured do not count toward the timeout.
    read_timeout_counter #(
        .TERMINAL_COUNT (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clk        (clk),
        .nrst       (nrst),
        .clear_i    (accept),
        .enable_i   (in_wait && !mem_ready && !rd_done_q),
        .terminal_o (terminal)
    );

    assign timeout_hit   = terminal && !mem_ready;
    assign timeout_error = timeout_error_q;
`else
    assign timeout_error = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        data_latch_d  = data_latch_q;
        data_valid_d  = 1'b0;
        rd_done_d     = rd_done_q;
        rd_data_d     = rd_data_q;
`ifdef BUS_READER_TIMEOUT_EN
        timeout_error_d = timeout_error_q;
`endif
        case (state_q)
            dataflow_pkg::ST_IDLE: begin
                if (read_request) begin
                    mem_address_d = {address_high_in, address_low_in};
                    rd_done_d     = 1'b0;
`ifdef BUS_READER_TIMEOUT_EN
                    timeout_error_d = 1'b0;
`endif
                    state_d       = dataflow_pkg::ST_WAIT;
                end
            end
            dataflow_pkg::ST_WAIT: begin
                if (rd_done_q) begin
                    data_latch_d = rd_data_q;
                    data_valid_d = 1'b1;
                    rd_done_d    = 1'b0;
                    state_d      = dataflow_pkg::ST_IDLE;
                end else if (mem_ready) begin
                    rd_done_d = 1'b1;
                    rd_data_d = mem_data;
`ifdef BUS_READER_TIMEOUT_EN
                end else if (timeout_hit) begin
                    data_latch_d    = DEFAULT_DATA;
                    data_valid_d    = 1'b1;
                    timeout_error_d = 1'b1;
                    state_d         = dataflow_pkg::ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = dataflow_pkg::ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= dataflow_pkg::ST_IDLE;
            mem_address_q <= '0;
            data_latch_q  <= DEFAULT_DATA;
            data_valid_q  <= 1'b0;
            rd_done_q     <= 1'b0;
            rd_data_q     <= '0;
`ifdef BUS_READER_TIMEOUT_EN
            timeout_error_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            data_latch_q  <= data_latch_d;
            data_valid_q  <= data_valid_d;
            rd_done_q     <= rd_done_d;
            rd_data_q     <= rd_data_d;
`ifdef BUS_READER_TIMEOUT_EN
            timeout_error_q <= timeout_error_d;
`endif
        end
    end

endmodule

// File: tb/tb_external_bus_reader.sv
// tb/tb_external_bus_reader.sv - self-checking bench for external_bus_reader
module tb_external_bus_reader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  abl, abh;
    logic        req;
    logic [15:0] mem_address;
    logic        mem_read_valid;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic [7:0]  data_latch_out;
    logic        data_valid;
    logic        stall;
    logic        timeout_error;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];

    external_bus_reader #(
        .DEFAULT_DATA   (8'hEA),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .address_low_in  (abl),
        .address_high_in (abh),
        .read_request    (req),
        .mem_address     (mem_address),
        .mem_read_valid  (mem_read_valid),
        .mem_ready       (mem_ready),
        .mem_data        (mem_data),
        .data_latch_out  (data_latch_out),
        .data_valid      (data_valid),
        .stall           (stall),
        .timeout_error   (timeout_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every data_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dv: pulse with empty scoreboard, latch %0h", data_latch_out);
            end else begin
                check("sb_data", {24'h0, data_latch_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         nwait;
        logic [7:0] data;
        logic [7:0] exp_data;
        int         exp_stall;
        logic       exp_terr;
    } vec_t;

    vec_t vecs[$];

    // One read; memory holds mem_ready low for nwait WAIT cycles, then high.
    task automatic do_read(input vec_t v);
        int k;
        @(negedge clk);
        abh = v.hi;
        abl = v.lo;
        req = 1'b1;
        mem_ready = 1'b0;
        exp_q.push_back(v.exp_data);
        @(negedge clk);
        req = 1'b0;
        abh = ~v.hi;
        abl = ~v.lo;
        check("rd_valid_first", {31'h0, mem_read_valid}, 32'h1);
        check("rd_addr_capture", {16'h0, mem_address}, {16'h0, v.hi, v.lo});
        k = 0;
        while (stall && k < 100) begin
            k++;
            mem_ready = (k > v.nwait);
            mem_data  = (k > v.nwait) ? v.data : ~v.data;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("rd_stall_cycles", k, v.exp_stall);
        check("rd_dv", {31'h0, data_valid}, 32'h1);
        check("rd_latch", {24'h0, data_latch_out}, {24'h0, v.exp_data});
        check("rd_terr", {31'h0, timeout_error}, {31'h0, v.exp_terr});
        check("rd_addr_hold", {16'h0, mem_address}, {16'h0, v.hi, v.lo});
        @(negedge clk);
        check("rd_dv_one_cycle", {31'h0, data_valid}, 32'h0);
    endtask

    initial begin
        int pulse_at[3];
        int np;

        nrst = 1'b0; req = 1'b0; abl = 8'h00; abh = 8'h00;
        mem_ready = 1'b0; mem_data = 8'h00;
        pulse_at[0] = 0; pulse_at[1] = 0; pulse_at[2] = 0;

        repeat (3) @(negedge clk);
        check("rst_addr", {16'h0, mem_address}, 32'h0);
        check("rst_latch", {24'h0, data_latch_out}, 32'hEA);
        check("rst_dv", {31'h0, data_valid}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_rdvalid", {31'h0, mem_read_valid}, 32'h0);
        check("rst_terr", {31'h0, timeout_error}, 32'h0);
        nrst = 1'b1;

        vecs.push_back('{8'h12, 8'h34, 0, 8'hA9, 8'hA9, 2, 1'b0});
        vecs.push_back('{8'h56, 8'h78, 5, 8'h5C, 8'h5C, 7, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1, 8'h3C, 8'h3C, 3, 1'b0});
`ifdef BUS_READER_TIMEOUT_EN
        vecs.push_back('{8'hAB, 8'hCD, 200, 8'h77, 8'hEA, TO, 1'b1});
        vecs.push_back('{8'h00, 8'hFF, 0, 8'h11, 8'h11, 2, 1'b0});
        vecs.push_back('{8'h9A, 8'hBC, TO - 1, 8'hC3, 8'hC3, TO + 1, 1'b0});
        vecs.push_back('{8'h01, 8'h02, TO - 2, 8'hD2, 8'hD2, TO, 1'b0});
`else
        vecs.push_back('{8'hAB, 8'hCD, 20, 8'h77, 8'h77, 22, 1'b0});
        vecs.push_back('{8'h9A, 8'hBC, TO - 1, 8'hC3, 8'hC3, TO + 1, 1'b0});
`endif
        foreach (vecs[i]) do_read(vecs[i]);

        // Back-to-back: request held high across three reads.
        @(negedge clk);
        abh = 8'hC0; abl = 8'h00; req = 1'b1; mem_ready = 1'b1; mem_data = 8'h01;
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        np = 0;
        for (int cyc = 0; cyc < 30 && np < 3; cyc++) begin
            @(negedge clk);
            if (data_valid) begin
                pulse_at[np] = cyc;
                check("b2b_idle_at_pulse", {31'h0, stall}, 32'h0);
                np++;
                mem_data = 8'(np + 1);
                if (np == 3) begin
                    req = 1'b0;
                    mem_ready = 1'b0;
                end
            end
        end
        check("b2b_pulses", np, 3);
        check("b2b_gap1", pulse_at[1] - pulse_at[0], 3);
        check("b2b_gap2", pulse_at[2] - pulse_at[1], 3);
        repeat (3) @(negedge clk);
        check("b2b_settled", {31'h0, stall}, 32'h0);

        // Reset on the third WAIT cycle.
        abh = 8'h44; abl = 8'h55; req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstw_in_wait", {31'h0, stall}, 32'h1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("rstw_stall", {31'h0, stall}, 32'h0);
        check("rstw_rdvalid", {31'h0, mem_read_valid}, 32'h0);
        check("rstw_latch", {24'h0, data_latch_out}, 32'hEA);
        check("rstw_dv", {31'h0, data_valid}, 32'h0);
        check("rstw_addr", {16'h0, mem_address}, 32'h0);
        repeat (3) @(negedge clk);
        check("rstw_stays_idle", {31'h0, stall}, 32'h0);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
